// File: rtl/ifetch_arb_pkg.sv
// Shared definitions for the instruction-fetch arbiter: requester IDs,
// tracker entry layout and the default starvation limit.
package ifetch_arb_pkg;

    typedef enum logic {
        ReqF = 1'b0,
        ReqA = 1'b1
    } req_id_e;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

    typedef struct packed {
        req_id_e id;
        logic    discard;
    } trk_entry_t;

endpackage

// File: rtl/ifetch_arb_if.sv
// Requester and instruction-memory bus seen by the fetch arbiter.
interface ifetch_arb_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   f_req;
    logic [ADDR_WIDTH-1:0]  f_addr;
    logic                   f_flush;
    logic                   f_gnt;
    logic                   f_rvalid;
    logic [INSTR_WIDTH-1:0] f_rdata;
    logic                   a_req;
    logic [ADDR_WIDTH-1:0]  a_addr;
    logic                   a_gnt;
    logic                   a_rvalid;
    logic [INSTR_WIDTH-1:0] a_rdata;
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic                   resp_err;

    modport slave (
        input  f_req, f_addr, f_flush, a_req, a_addr, mem_gnt, mem_rvalid, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, a_gnt, a_rvalid, a_rdata, mem_req, mem_addr,
        resp_err
    );

    modport master (
        output f_req, f_addr, f_flush, a_req, a_addr, mem_gnt, mem_rvalid, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, a_gnt, a_rvalid, a_rdata, mem_req, mem_addr,
        resp_err
    );
endinterface

// File: rtl/ifetch_arb_trk.sv
// Two-entry in-order tracker of outstanding memory requests; a fetch flush marks
// every live fetch entry (including the one popping this cycle) as discard.
module ifetch_arb_trk
    import ifetch_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  req_id_e    push_id,
    input  logic       pop_req,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output logic       pop,
    output trk_entry_t head
);

    trk_entry_t [1:0] ent_q, ent_d;
    logic [1:0]       cnt_q, cnt_d;

    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);
    assign pop   = pop_req && !empty;

    always_comb begin
        head = ent_q[0];
        if (flush && ent_q[0].id == ReqF) head.discard = 1'b1;
    end

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (flush) begin
            if (cnt_q >= 2'd1 && ent_q[0].id == ReqF) ent_d[0].discard = 1'b1;
            if (cnt_q == 2'd2 && ent_q[1].id == ReqF) ent_d[1].discard = 1'b1;
        end
        if (pop) begin
            ent_d[0] = ent_d[1];
            ent_d[1] = '0;
            cnt_d    = cnt_q - 2'd1;
        end
        // Push lands behind whatever survives the pop, so the older entry always leaves first.
        if (push && !full) begin
            if (cnt_d == 2'd0) ent_d[0] = '{id: push_id, discard: 1'b0};
            else               ent_d[1] = '{id: push_id, discard: 1'b0};
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifetch_arb.sv
// Arbitrates instruction fetch and aux requests onto one memory port, with a
// starvation guard for aux and in-order response routing via the tracker.
module ifetch_arb
    import ifetch_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    ifetch_arb_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                   f_req_e, sel_aux, accept;
    logic                   trk_full, trk_empty, trk_pop;
    trk_entry_t             trk_head;
    logic [3:0]             starve_q, starve_d;
    logic                   resp_err_q;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [INSTR_WIDTH-1:0] rdata;

    assign f_req_e  = bus.f_req && !bus.f_flush;
    assign sel_aux  = bus.a_req && (!f_req_e || starve_q == LIMIT);
    assign sel_addr = sel_aux ? bus.a_addr : bus.f_addr;

    // Reset gating keeps the memory port quiet while the tracker is held empty.
    assign bus.mem_req  = (f_req_e || bus.a_req) && !trk_full && !cpu_rst;
    assign bus.mem_addr = sel_addr;
    assign accept       = bus.mem_req && bus.mem_gnt;
    assign bus.f_gnt    = accept && !sel_aux;
    assign bus.a_gnt    = accept && sel_aux;

    ifetch_arb_trk u_trk (
        .clk     (cpu_clk),
        .rst     (cpu_rst),
        .push    (accept),
        .push_id (sel_aux ? ReqA : ReqF),
        .pop_req (bus.mem_rvalid),
        .flush   (bus.f_flush),
        .full    (trk_full),
        .empty   (trk_empty),
        .pop     (trk_pop),
        .head    (trk_head)
    );

    assign rdata        = bus.mem_rdata;
    assign bus.f_rdata  = rdata;
    assign bus.a_rdata  = rdata;
    assign bus.f_rvalid = trk_pop && trk_head.id == ReqF && !trk_head.discard;
    assign bus.a_rvalid = trk_pop && trk_head.id == ReqA;
    assign bus.resp_err = resp_err_q;

    always_comb begin
        starve_d = starve_q;
        if (!bus.a_req || bus.a_gnt) begin
            starve_d = 4'd0;
        end else if (bus.f_gnt && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            starve_q   <= 4'd0;
            resp_err_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (bus.mem_rvalid && trk_empty) resp_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifetch_arb.sv
// Directed vector bench for ifetch_arb: a cycle-by-cycle table plus hand-written
// sequences for starvation, async reset and reset with requests outstanding.
module tb_ifetch_arb;
    import ifetch_arb_pkg::*;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;

    ifetch_arb_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    ifetch_arb #(
        .ADDR_WIDTH   (32),
        .INSTR_WIDTH  (32),
        .STARVE_LIMIT (8)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus.slave)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        f_req;
        logic [31:0] f_addr;
        logic        f_flush;
        logic        a_req;
        logic [31:0] a_addr;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic [31:0] e_mem_addr;
        logic        e_f_gnt;
        logic        e_a_gnt;
        logic        e_f_rvalid;
        logic        e_a_rvalid;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic fr, logic [31:0] fa, logic fl, logic ar,
                                logic [31:0] aa, logic g, logic rv, logic [31:0] rd,
                                logic emr, logic [31:0] ema, logic efg, logic eag,
                                logic efv, logic eav, logic eer);
        vec_t v;
        v.name = nm;       v.f_req = fr;      v.f_addr = fa;     v.f_flush = fl;
        v.a_req = ar;      v.a_addr = aa;     v.mem_gnt = g;     v.mem_rvalid = rv;
        v.mem_rdata = rd;  v.e_mem_req = emr; v.e_mem_addr = ema;
        v.e_f_gnt = efg;   v.e_a_gnt = eag;   v.e_f_rvalid = efv; v.e_a_rvalid = eav;
        v.e_err = eer;
        return v;
    endfunction

    task automatic drive(input logic fr, input logic [31:0] fa, input logic fl, input logic ar,
                         input logic [31:0] aa, input logic g, input logic rv,
                         input logic [31:0] rd);
        bus.f_req = fr;      bus.f_addr = fa;     bus.f_flush = fl;
        bus.a_req = ar;      bus.a_addr = aa;     bus.mem_gnt = g;
        bus.mem_rvalid = rv; bus.mem_rdata = rd;
    endtask

    task automatic check(input string nm, input logic emr, input logic [31:0] ema,
                         input logic efg, input logic eag, input logic efv, input logic eav,
                         input logic eer, input logic [31:0] erd);
        logic [37:0] got, exp;
        logic [31:0] got_rd, exp_rd;
        got = {bus.mem_req, bus.mem_addr, bus.f_gnt, bus.a_gnt, bus.f_rvalid, bus.a_rvalid,
               bus.resp_err};
        exp = {emr, ema, efg, eag, efv, eav, eer};
        exp_rd = (efv || eav) ? erd : 32'h0;
        got_rd = efv ? bus.f_rdata : (eav ? bus.a_rdata : 32'h0);
        n_vec++;
        if (got !== exp || got_rd !== exp_rd) begin
            n_bad++;
            $display("FAIL %s: got mem_req=%b addr=%h f_gnt=%b a_gnt=%b f_rv=%b a_rv=%b err=%b rd=%h, required mem_req=%b addr=%h f_gnt=%b a_gnt=%b f_rv=%b a_rv=%b err=%b rd=%h",
                     nm, got[37], got[36:5], got[4], got[3], got[2], got[1], got[0], got_rd,
                     exp[37], exp[36:5], exp[4], exp[3], exp[2], exp[1], exp[0], exp_rd);
        end
    endtask

    initial begin
        //            name        fr fa         fl ar aa         g  rv rd            mr ma         fg ag fv av er
        tbl.push_back(mk("idle",       0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h0,     0, 0, 0, 0, 0));
        tbl.push_back(mk("f_grant",    1, 32'h100,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h100,   1, 0, 0, 0, 0));
        tbl.push_back(mk("f_resp",     0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h00008067, 0, 32'h0,     0, 0, 1, 0, 0));
        tbl.push_back(mk("fill_1",     1, 32'h104,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h104,   1, 0, 0, 0, 0));
        tbl.push_back(mk("fill_2",     1, 32'h108,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h108,   1, 0, 0, 0, 0));
        tbl.push_back(mk("full_block", 1, 32'h10c,   0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h10c,   0, 0, 0, 0, 0));
        tbl.push_back(mk("flush",      1, 32'h10c,   1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h10c,   0, 0, 0, 0, 0));
        tbl.push_back(mk("full_pop",   1, 32'h110,   0, 0, 32'h0,     1, 1, 32'h11,       0, 32'h110,   0, 0, 0, 0, 0));
        tbl.push_back(mk("disc_2",     1, 32'h110,   0, 0, 32'h0,     0, 1, 32'h12,       1, 32'h110,   0, 0, 0, 0, 0));
        tbl.push_back(mk("refetch",    1, 32'h110,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h110,   1, 0, 0, 0, 0));
        tbl.push_back(mk("refet_rsp",  0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h13,       0, 32'h0,     0, 0, 1, 0, 0));
        tbl.push_back(mk("fa_f",       1, 32'h200,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h200,   1, 0, 0, 0, 0));
        tbl.push_back(mk("fa_a",       0, 32'h0,     0, 1, 32'h300,   1, 0, 32'h0,        1, 32'h300,   0, 1, 0, 0, 0));
        tbl.push_back(mk("fa_flush",   0, 32'h0,     1, 0, 32'h0,     0, 0, 32'h0,        0, 32'h0,     0, 0, 0, 0, 0));
        tbl.push_back(mk("fa_rsp_f",   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h0000aaaa, 0, 32'h0,     0, 0, 0, 0, 0));
        tbl.push_back(mk("fa_rsp_a",   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h0000bbbb, 0, 32'h0,     0, 0, 0, 1, 0));
        tbl.push_back(mk("hp_f",       1, 32'h400,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h400,   1, 0, 0, 0, 0));
        tbl.push_back(mk("hp_flush",   0, 32'h0,     1, 0, 32'h0,     0, 1, 32'h5,        0, 32'h0,     0, 0, 0, 0, 0));
        tbl.push_back(mk("pp_f",       1, 32'h500,   0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h500,   1, 0, 0, 0, 0));
        tbl.push_back(mk("pp_both",    0, 32'h0,     0, 1, 32'h600,   1, 1, 32'h77,       1, 32'h600,   0, 1, 1, 0, 0));
        tbl.push_back(mk("pp_a_rsp",   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h88,       0, 32'h0,     0, 0, 0, 1, 0));
        tbl.push_back(mk("prio_stall", 1, 32'h700,   0, 1, 32'h800,   0, 0, 32'h0,        1, 32'h700,   0, 0, 0, 0, 0));
        tbl.push_back(mk("a_stall",    0, 32'h0,     0, 1, 32'h800,   0, 0, 32'h0,        1, 32'h800,   0, 0, 0, 0, 0));
        tbl.push_back(mk("stray_rv",   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h99,       0, 32'h0,     0, 0, 0, 0, 0));
        tbl.push_back(mk("err_set",    0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h0,     0, 0, 0, 0, 1));
        tbl.push_back(mk("err_hold",   0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h0,     0, 0, 0, 0, 1));

        // Outputs while held in reset, with a request pending.
        drive(1, 32'h100, 0, 1, 32'h0, 1, 0, 32'h0);
        #2;
        check("rst_outputs", 0, 32'h100, 0, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge cpu_clk);
            drive(tbl[i].f_req, tbl[i].f_addr, tbl[i].f_flush, tbl[i].a_req, tbl[i].a_addr,
                  tbl[i].mem_gnt, tbl[i].mem_rvalid, tbl[i].mem_rdata);
            #2;
            check(tbl[i].name, tbl[i].e_mem_req, tbl[i].e_mem_addr, tbl[i].e_f_gnt,
                  tbl[i].e_a_gnt, tbl[i].e_f_rvalid, tbl[i].e_a_rvalid, tbl[i].e_err,
                  tbl[i].mem_rdata);
        end

        // resp_err must clear with no clock edge in between.
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        #1 cpu_rst = 1'b1;
        #1 check("err_async_clr", 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Starvation: eight fetch grants, then aux, then fetch wins again.
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge cpu_clk);
            drive(1, 32'h1000, 0, 1, 32'h2000, 1, (i > 0), 32'(i));
            #2;
            if (i < 8)
                check($sformatf("starve_f%0d", i), 1, 32'h1000, 1, 0, (i > 0), 0, 0, 32'(i));
            else if (i == 8)
                check("starve_a", 1, 32'h2000, 0, 1, 1, 0, 0, 32'(i));
            else
                check("starve_clr", 1, 32'h1000, 1, 0, 0, 1, 0, 32'(i));
        end
        @(negedge cpu_clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h55);
        #2 check("starve_drain", 0, 32'h0, 0, 0, 1, 0, 0, 32'h55);

        // Reset with one fetch outstanding.
        @(negedge cpu_clk);
        drive(1, 32'h3000, 0, 0, 32'h0, 1, 0, 32'h0);
        #2 check("rm_grant", 1, 32'h3000, 1, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        drive(1, 32'h3004, 0, 0, 32'h0, 1, 0, 32'h0);
        #1 cpu_rst = 1'b1;
        #1 check("rm_in_rst", 0, 32'h3004, 0, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        drive(1, 32'h3008, 0, 0, 32'h0, 1, 0, 32'h0);
        #2 check("rm_post_1", 1, 32'h3008, 1, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        drive(1, 32'h300c, 0, 0, 32'h0, 1, 0, 32'h0);
        #2 check("rm_post_2", 1, 32'h300c, 1, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        drive(1, 32'h3010, 0, 0, 32'h0, 1, 0, 32'h0);
        #2 check("rm_full", 0, 32'h3010, 0, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'ha);
        #2 check("rm_rsp_1", 0, 32'h0, 0, 0, 1, 0, 0, 32'ha);
        @(negedge cpu_clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hb);
        #2 check("rm_rsp_2", 0, 32'h0, 0, 0, 1, 0, 0, 32'hb);
        @(negedge cpu_clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hc);
        #2 check("rm_stale", 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge cpu_clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        #2 check("rm_err", 0, 32'h0, 0, 0, 0, 0, 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_arb.md
IFETCH_ARB -- requirements
Module: ifetch_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all requester and memory ports.
REQ-002 Parameter INSTR_WIDTH, default 32, read-data width.
REQ-003 Parameter STARVE_LIMIT, default 8, consecutive aux-blocked fetch grants before aux is forced; range 1..15.
REQ-004 cpu_clk  in  1  single clock; all state on rising edge.
REQ-005 cpu_rst  in  1  reset, asynchronous, active-high.
REQ-006 f_req  in  1  fetch request valid.
REQ-007 f_addr  in  ADDR_WIDTH  fetch address.
REQ-008 f_flush  in  1  fetch redirect; discard all in-flight fetch responses.
REQ-009 f_gnt  out  1  fetch request accepted this cycle.
REQ-010 f_rvalid  out  1  fetch response valid.
REQ-011 f_rdata  out  INSTR_WIDTH  fetch response data.
REQ-012 a_req  in  1  aux (debug/loader) request valid.
REQ-013 a_addr  in  ADDR_WIDTH  aux address.
REQ-014 a_gnt  out  1  aux request accepted this cycle.
REQ-015 a_rvalid  out  1  aux response valid.
REQ-016 a_rdata  out  INSTR_WIDTH  aux response data.
REQ-017 mem_req  out  1  request to instruction memory.
REQ-018 mem_addr  out  ADDR_WIDTH  memory address.
REQ-019 mem_gnt  in  1  memory accepts request this cycle.
REQ-020 mem_rvalid  in  1  memory response valid, in request order.
REQ-021 mem_rdata  in  INSTR_WIDTH  memory response data.
REQ-022 resp_err  out  1  sticky: mem_rvalid received with no request outstanding.

Function
REQ-023 Effective fetch request f_req_e = f_req && !f_flush; a fetch request in a flush cycle is never granted.
REQ-024 Selection: aux when a_req && (!f_req_e || starve_cnt == STARVE_LIMIT), else fetch.
REQ-025 mem_req = (f_req_e || a_req) && !full; mem_addr = address of selected requester; both combinational.
REQ-026 f_gnt / a_gnt = mem_req && mem_gnt && selected requester; at most one asserted per cycle.
REQ-027 Tracker: 2-entry in-order FIFO of {id (F/A), discard}; push {sel, 0} on mem_req && mem_gnt; pop on mem_rvalid when not empty.
REQ-028 full = (count == 2); when full mem_req is 0 even if a pop occurs that cycle.
REQ-029 Simultaneous push and pop with count 1: count stays 1, popped entry is the older.
REQ-030 f_flush sets discard on every valid F entry that cycle, including the head popped that cycle (its response is suppressed); A entries untouched.
REQ-031 f_rvalid = mem_rvalid && !empty && head.id == F && !head.discard; a_rvalid = mem_rvalid && !empty && head.id == A; zero-cycle combinational pass-through.
REQ-032 f_rdata and a_rdata = mem_rdata unconditionally (qualified by rvalid).
REQ-033 mem_rvalid while empty: no pop, no rvalid output, resp_err set to 1 on next edge, held until reset.
REQ-034 starve_cnt (4 bits): cleared when a_req is 0 or a_gnt is 1; incremented, saturating at STARVE_LIMIT, when a_req && f_gnt.
REQ-035 Memory stall (mem_gnt 0) leaves starve_cnt, selection, and FIFO unchanged.

Reset
REQ-036 On cpu_rst assertion: FIFO count 0, entries cleared, starve_cnt 0, resp_err 0, immediately, without a clock.
REQ-037 Reset mid-transaction drops all outstanding entries; later mem_rvalid for them sets resp_err (memory is reset on the same signal in the system).
REQ-038 During reset all grant/rvalid outputs and mem_req are 0.

Structure
REQ-039 Requester ID encoding (F=0, A=1) and the STARVE_LIMIT default live in the shared core defines package.
REQ-040 One sub-module, ifetch_arb_trk, implements the 2-entry tracker FIFO with discard marking; arbitration and the starvation counter stay in ifetch_arb.

Verification
REQ-041 f_req=1 @0x100, mem_gnt=1, mem_rvalid next cycle with data 0x00008067 -> f_gnt=1, then f_rvalid=1, f_rdata=0x00008067, a_rvalid=0.
REQ-042 f_req and a_req held 1, mem_gnt=1, rvalid each cycle, STARVE_LIMIT=8 -> 8 fetch grants, a_gnt in cycle 9, starve_cnt returns to 0.
REQ-043 Two fetch grants outstanding (count 2), f_req=1 -> mem_req=0; f_flush pulse; two mem_rvalid -> f_rvalid stays 0, both entries popped, mem_req reasserts.
REQ-044 Fetch then aux granted back to back, f_flush before responses -> first response suppressed, second gives a_rvalid=1 with its data.
REQ-045 mem_rvalid=1 with empty tracker -> no rvalid outputs, resp_err=1 next cycle and held; cpu_rst clears it asynchronously.
REQ-046 cpu_rst asserted with 1 entry outstanding -> count 0 immediately, mem_req=0 during reset, normal grant on first cycle after release.
